// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I decode stage.
//   - ALU op codes ({funct7[5], funct3} style, shared with the ALU)
//   - base opcode constants
//   - operand-select and instruction-class enums
//   - packed decode bundle carried from decode to execute
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // ALU op codes
    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSll  = 4'b0001;
    localparam logic [3:0] AluSlt  = 4'b0010;
    localparam logic [3:0] AluSltu = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSrl  = 4'b0101;
    localparam logic [3:0] AluOr   = 4'b0110;
    localparam logic [3:0] AluAnd  = 4'b0111;
    localparam logic [3:0] AluSub  = 4'b1000;
    localparam logic [3:0] AluSra  = 4'b1101;

    // Base opcodes (full 7 bits, so 16-bit encodings never match)
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    typedef enum logic [1:0] {
        ASelRs1  = 2'd0,
        ASelPc   = 2'd1,
        ASelZero = 2'd2
    } a_sel_e;

    typedef enum logic {
        BSelRs2 = 1'b0,
        BSelImm = 1'b1
    } b_sel_e;

    typedef enum logic [3:0] {
        ClsIllegal = 4'd0,
        ClsAlu     = 4'd1,
        ClsAluImm  = 4'd2,
        ClsLoad    = 4'd3,
        ClsStore   = 4'd4,
        ClsBranch  = 4'd5,
        ClsJal     = 4'd6,
        ClsJalr    = 4'd7,
        ClsLui     = 4'd8,
        ClsAuipc   = 4'd9,
        ClsFence   = 4'd10,
        ClsSystem  = 4'd11
    } instr_class_e;

    typedef struct packed {
        logic [31:0]  pc;
        logic [3:0]   alu_op;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic [31:0]  imm;
        a_sel_e       a_sel;
        b_sel_e       b_sel;
        instr_class_e cls;
        logic         wb_en;
        logic         illegal;
    } decode_t;

endpackage

// File: rtl/cpu_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J format from the opcode and
// returns the sign-extended immediate (sign bit is always instr[31]).
//   instr  in   32  instruction word
//   imm    out  32  format-selected immediate, 0 for formats without one
module cpu_imm_gen
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        unique case (instr[6:0])
            OpcOpImm, OpcLoad, OpcJalr, OpcMiscMem, OpcSystem:
                imm = {{20{instr[31]}}, instr[31:20]};
            OpcStore:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OpcBranch:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OpcLui, OpcAuipc:
                imm = {instr[31:12], 12'b0};
            OpcJal:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/cpu_decode.sv
// RV32I decode stage with a registered output bundle and a 2-entry skid
// buffer (output reg + skid reg), so o_ready comes straight from a flop.
//   i_clk, i_rst           clock, async active-high reset
//   i_flush                drop everything held or accepted this cycle
//   i_valid/o_ready        upstream handshake (i_instr, i_pc)
//   o_valid/i_ready        downstream handshake
//   o_pc .. o_illegal      registered decode bundle
module cpu_decode
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [3:0]      o_alu_op,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_imm,
    output logic [1:0]      o_a_sel,
    output logic            o_b_sel,
    output logic [3:0]      o_class,
    output logic            o_wb_en,
    output logic            o_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        illegal;
    logic        writes_rd;
    decode_t     dec;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    cpu_imm_gen u_imm_gen (
        .instr (i_instr),
        .imm   (imm)
    );

    // Combinational decode of the incoming instruction
    always_comb begin
        dec       = '0;
        dec.pc    = i_pc;
        dec.rs1   = i_instr[19:15];
        dec.rs2   = i_instr[24:20];
        dec.rd    = i_instr[11:7];
        dec.imm   = imm;
        dec.a_sel = ASelRs1;
        dec.b_sel = BSelRs2;
        dec.cls   = ClsIllegal;
        alu_op    = AluAdd;
        illegal   = 1'b0;
        writes_rd = 1'b0;

        // All known opcodes end in 2'b11, so compressed encodings land in default.
        unique case (opcode)
            OpcOp: begin
                dec.cls   = ClsAlu;
                writes_rd = 1'b1;
                alu_op    = {funct7[5], funct3};
                if (!(funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                    illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                dec.cls   = ClsAluImm;
                dec.b_sel = BSelImm;
                writes_rd = 1'b1;
                // Only the right-shift pair uses funct7[5] to pick SRA over SRL
                alu_op    = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                if (funct3 == 3'b001 && funct7 != 7'h00) begin
                    illegal = 1'b1;
                end
                if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20) begin
                    illegal = 1'b1;
                end
            end
            OpcLoad: begin
                dec.cls   = ClsLoad;
                dec.b_sel = BSelImm;
                writes_rd = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    illegal = 1'b1;
                end
            end
            OpcStore: begin
                dec.cls   = ClsStore;
                dec.b_sel = BSelImm;
                if (funct3 > 3'b010) begin
                    illegal = 1'b1;
                end
            end
            OpcBranch: begin
                dec.cls = ClsBranch;
                case (funct3[2:1])
                    2'b00:   alu_op = AluSub;
                    2'b10:   alu_op = AluSlt;
                    2'b11:   alu_op = AluSltu;
                    default: illegal = 1'b1;
                endcase
            end
            OpcJal: begin
                dec.cls   = ClsJal;
                dec.a_sel = ASelPc;
                dec.b_sel = BSelImm;
                writes_rd = 1'b1;
            end
            OpcJalr: begin
                dec.cls   = ClsJalr;
                dec.b_sel = BSelImm;
                writes_rd = 1'b1;
            end
            OpcLui: begin
                dec.cls   = ClsLui;
                dec.a_sel = ASelZero;
                dec.b_sel = BSelImm;
                writes_rd = 1'b1;
            end
            OpcAuipc: begin
                dec.cls   = ClsAuipc;
                dec.a_sel = ASelPc;
                dec.b_sel = BSelImm;
                writes_rd = 1'b1;
            end
            OpcMiscMem: begin
                // Plain FENCE only; FENCE.I is not supported
                dec.cls = ClsFence;
                if (funct3 != 3'b000) begin
                    illegal = 1'b1;
                end
            end
            OpcSystem: begin
                // ECALL / EBREAK only; no CSR access in this core
                dec.cls = ClsSystem;
                if (i_instr != 32'h0000_0073 && i_instr != 32'h0010_0073) begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            dec.cls = ClsIllegal;
        end
        dec.illegal = illegal;
        dec.alu_op  = illegal ? AluAdd : alu_op;
        dec.wb_en   = writes_rd && !illegal && (dec.rd != 5'd0);
    end

    // Output register + skid register
    decode_t out_q, out_d, skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    ready_q;
    logic    accept;
    logic    out_free;

    assign accept   = i_valid && ready_q;
    assign out_free = !out_valid_q || i_ready;

    // ready_q always equals !skid_valid_q, so an accept never meets a full skid.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = out_valid_q;
    assign o_pc      = out_q.pc;
    assign o_alu_op  = out_q.alu_op;
    assign o_rs1     = out_q.rs1;
    assign o_rs2     = out_q.rs2;
    assign o_rd      = out_q.rd;
    assign o_imm     = out_q.imm;
    assign o_a_sel   = out_q.a_sel;
    assign o_b_sel   = out_q.b_sel;
    assign o_class   = out_q.cls;
    assign o_wb_en   = out_q.wb_en;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_cpu_decode.sv
// Self-checking bench for cpu_decode: directed cases plus randomized
// instruction/handshake traffic, checked through an expected-bundle queue.
module tb_cpu_decode;
    import cpu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst, i_flush, i_valid, i_ready;
    logic [31:0] i_instr, i_pc;
    logic        o_ready, o_valid;
    logic [31:0] o_pc, o_imm;
    logic [3:0]  o_alu_op, o_class;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [1:0]  o_a_sel;
    logic        o_b_sel, o_wb_en, o_illegal;

    always #5 i_clk = ~i_clk;

    cpu_decode #(.XLEN(32)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (i_flush),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_instr   (i_instr),
        .i_pc      (i_pc),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_pc      (o_pc),
        .o_alu_op  (o_alu_op),
        .o_rs1     (o_rs1),
        .o_rs2     (o_rs2),
        .o_rd      (o_rd),
        .o_imm     (o_imm),
        .o_a_sel   (o_a_sel),
        .o_b_sel   (o_b_sel),
        .o_class   (o_class),
        .o_wb_en   (o_wb_en),
        .o_illegal (o_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_op;
        logic [3:0]  cls;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic        wb_en;
        logic        illegal;
        logic        chk_cls;
        logic        chk_rs1;
        logic        chk_rs2;
        logic        chk_rd;
        logic        chk_imm;
        logic        chk_sel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    bit   rand_ready = 1'b0;
    logic mon_bad;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference decode, built directly from the ISA field rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        int          imm_i, imm_s, imm_b, imm_j;
        bit          bad = 0;
        bit          writes = 0;
        imm_i = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        imm_s = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        imm_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2;
        imm_j = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
              + int'(ins[30:21]) * 2;
        e = '0;
        e.pc  = pc;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.chk_cls = 1;
        case (ins[6:0])
            OpcOp: begin
                e.cls = ClsAlu; e.a_sel = ASelRs1; e.b_sel = BSelRs2; e.alu_op = {f7[5], f3};
                bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
                writes = 1; e.chk_rs1 = 1; e.chk_rs2 = 1; e.chk_rd = 1; e.chk_sel = 1;
            end
            OpcOpImm: begin
                e.cls = ClsAluImm; e.a_sel = ASelRs1; e.b_sel = BSelImm;
                e.alu_op = (f3 == 5) ? {f7[5], f3} : {1'b0, f3};
                bad = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 7'h20));
                e.imm = 32'(imm_i); writes = 1;
                e.chk_rs1 = 1; e.chk_rd = 1; e.chk_imm = 1; e.chk_sel = 1;
            end
            OpcLoad: begin
                e.cls = ClsLoad; e.a_sel = ASelRs1; e.b_sel = BSelImm;
                bad = (f3 == 3 || f3 == 6 || f3 == 7); e.imm = 32'(imm_i); writes = 1;
                e.chk_rs1 = 1; e.chk_rd = 1; e.chk_imm = 1; e.chk_sel = 1;
            end
            OpcStore: begin
                e.cls = ClsStore; e.a_sel = ASelRs1; e.b_sel = BSelImm;
                bad = (f3 > 2); e.imm = 32'(imm_s);
                e.chk_rs1 = 1; e.chk_rs2 = 1; e.chk_imm = 1; e.chk_sel = 1;
            end
            OpcBranch: begin
                e.cls = ClsBranch; e.a_sel = ASelRs1; e.b_sel = BSelRs2; e.imm = 32'(imm_b);
                if (f3 == 0 || f3 == 1) e.alu_op = 4'b1000;
                else if (f3 == 4 || f3 == 5) e.alu_op = 4'b0010;
                else if (f3 == 6 || f3 == 7) e.alu_op = 4'b0011;
                else bad = 1;
                e.chk_rs1 = 1; e.chk_rs2 = 1; e.chk_imm = 1; e.chk_sel = 1;
            end
            OpcJal: begin
                e.cls = ClsJal; e.a_sel = ASelPc; e.b_sel = BSelImm; e.imm = 32'(imm_j);
                writes = 1; e.chk_rd = 1; e.chk_imm = 1; e.chk_sel = 1;
            end
            OpcJalr: begin
                e.cls = ClsJalr; e.a_sel = ASelRs1; e.b_sel = BSelImm; e.imm = 32'(imm_i);
                writes = 1; e.chk_rs1 = 1; e.chk_rd = 1; e.chk_imm = 1; e.chk_sel = 1;
            end
            OpcLui: begin
                e.cls = ClsLui; e.a_sel = ASelZero; e.b_sel = BSelImm;
                e.imm = ins & 32'hFFFF_F000; writes = 1;
                e.chk_rd = 1; e.chk_imm = 1; e.chk_sel = 1;
            end
            OpcAuipc: begin
                e.cls = ClsAuipc; e.a_sel = ASelPc; e.b_sel = BSelImm;
                e.imm = ins & 32'hFFFF_F000; writes = 1;
                e.chk_rd = 1; e.chk_imm = 1; e.chk_sel = 1;
            end
            OpcMiscMem: begin
                e.cls = ClsFence; bad = (f3 != 0);
            end
            OpcSystem: begin
                e.cls = ClsSystem; bad = !(ins == 32'h0000_0073 || ins == 32'h0010_0073);
            end
            default: bad = 1;
        endcase
        e.illegal = bad;
        e.wb_en   = writes && !bad && (e.rd != 0);
        if (bad) begin
            e.alu_op = 4'b0000;
            e.chk_cls = 0; e.chk_rs1 = 0; e.chk_rs2 = 0; e.chk_rd = 0;
            e.chk_imm = 0; e.chk_sel = 0;
        end
        return e;
    endfunction

    function automatic logic [31:0] pick_f7();
        int r = $urandom_range(0, 3);
        logic [31:0] x = $urandom;
        if (r < 2) return 32'h00;
        if (r == 2) return 32'h20;
        return {25'b0, x[6:0]};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        logic [31:0] f;
        case ($urandom_range(0, 12))
            0:  begin w[6:0] = OpcOp;    f = pick_f7(); w[31:25] = f[6:0]; end
            1:  begin w[6:0] = OpcOpImm; f = pick_f7(); w[31:25] = f[6:0]; end
            2:  w[6:0] = OpcLoad;
            3:  w[6:0] = OpcStore;
            4:  w[6:0] = OpcBranch;
            5:  w[6:0] = OpcJal;
            6:  w[6:0] = OpcJalr;
            7:  w[6:0] = OpcLui;
            8:  w[6:0] = OpcAuipc;
            9:  begin w[6:0] = OpcMiscMem; w[14:12] = 3'b000; end
            10: w = ($urandom_range(0, 1) != 0) ? 32'h0000_0073 : 32'h0010_0073;
            default: ;
        endcase
        return w;
    endfunction

    // Called just after a rising edge; holds i_valid until accepted (bounded).
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        int waitc = 0;
        i_valid = 1'b1;
        i_instr = instr;
        i_pc    = pc;
        while (!o_ready && waitc < 50) begin
            @(posedge i_clk); #1;
            waitc++;
        end
        if (!o_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: o_ready stayed %b, required 1", o_ready);
        end else begin
            sb.push_back(model(instr, pc));
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int c = 0;
        while (sb.size() != 0 && c < bound) begin
            @(posedge i_clk); #1;
            c++;
        end
        chk(name, sb.size(), 0);
    endtask

    // Monitor: one scoreboard comparison per downstream transfer
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: got pc %h, required no output", o_pc);
                end else begin
                    mon_e = sb.pop_front();
                    n_out++;
                    n_checks++;
                    mon_bad = (o_pc !== mon_e.pc) || (o_illegal !== mon_e.illegal)
                        || (o_wb_en !== mon_e.wb_en) || (o_alu_op !== mon_e.alu_op)
                        || (mon_e.chk_cls && o_class !== mon_e.cls)
                        || (mon_e.chk_rs1 && o_rs1 !== mon_e.rs1)
                        || (mon_e.chk_rs2 && o_rs2 !== mon_e.rs2)
                        || (mon_e.chk_rd && o_rd !== mon_e.rd)
                        || (mon_e.chk_imm && o_imm !== mon_e.imm)
                        || (mon_e.chk_sel && (o_a_sel !== mon_e.a_sel || o_b_sel !== mon_e.b_sel));
                    if (mon_bad) begin
                        n_fail++;
                        $display("FAIL bundle: got pc=%h op=%h cls=%0d rs1=%0d rs2=%0d rd=%0d imm=%h a=%0d b=%0d wb=%b ill=%b; required pc=%h op=%h cls=%0d rs1=%0d rs2=%0d rd=%0d imm=%h a=%0d b=%0d wb=%b ill=%b",
                            o_pc, o_alu_op, o_class, o_rs1, o_rs2, o_rd, o_imm, o_a_sel, o_b_sel,
                            o_wb_en, o_illegal, mon_e.pc, mon_e.alu_op, mon_e.cls, mon_e.rs1,
                            mon_e.rs2, mon_e.rd, mon_e.imm, mon_e.a_sel, mon_e.b_sel,
                            mon_e.wb_en, mon_e.illegal);
                    end
                end
            end
            if (i_flush) sb.delete();
        end
    end

    always @(posedge i_clk) begin
        if (rand_ready) begin
            #1;
            i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_instr = '0; i_pc = '0;
        #12;
        chk("reset_o_valid", o_valid, 1'b0);
        chk("reset_o_ready", o_ready, 1'b1);
        chk("reset_o_pc", o_pc, 32'h0);
        chk("reset_o_alu_op", o_alu_op, 4'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Directed decodes with an always-ready consumer
        i_ready = 1'b1;
        send(32'h0050_0093, 32'h100);           // ADDI x1,x0,5
        chk("addi_valid", o_valid, 1'b1);
        chk("addi_alu_op", o_alu_op, 4'b0000);
        chk("addi_rd", o_rd, 5'd1);
        chk("addi_rs1", o_rs1, 5'd0);
        chk("addi_imm", o_imm, 32'd5);
        chk("addi_b_sel", o_b_sel, 1'b1);
        chk("addi_wb_en", o_wb_en, 1'b1);
        send(32'h4030_D113, 32'h104);           // SRAI x2,x1,3
        chk("srai_alu_op", o_alu_op, 4'b1101);
        chk("srai_rd", o_rd, 5'd2);
        chk("srai_rs1", o_rs1, 5'd1);
        chk("srai_shamt", {27'b0, o_imm[4:0]}, 32'd3);
        chk("srai_illegal", o_illegal, 1'b0);
        send(32'hFE20_ECE3, 32'h108);           // BLTU x1,x2,-8
        chk("bltu_alu_op", o_alu_op, 4'b0011);
        chk("bltu_imm", o_imm, 32'hFFFF_FFF8);
        chk("bltu_a_sel", o_a_sel, 2'd0);
        chk("bltu_b_sel", o_b_sel, 1'b0);
        chk("bltu_wb_en", o_wb_en, 1'b0);
        send(32'h0000_0000, 32'h10C);           // all-zero word
        chk("zero_valid", o_valid, 1'b1);
        chk("zero_illegal", o_illegal, 1'b1);
        chk("zero_wb_en", o_wb_en, 1'b0);
        chk("zero_alu_op", o_alu_op, 4'b0000);
        send(32'h0200_01B3, 32'h110);           // OP with funct7=0x01, rd=3
        chk("f7_01_illegal", o_illegal, 1'b1);
        chk("f7_01_wb_en", o_wb_en, 1'b0);
        chk("f7_01_alu_op", o_alu_op, 4'b0000);
        send(32'h0000_0073, 32'h114);           // ECALL
        chk("ecall_class", o_class, ClsSystem);
        chk("ecall_illegal", o_illegal, 1'b0);
        chk("ecall_wb_en", o_wb_en, 1'b0);
        wait_drain("directed_drain", 20);

        // Stall: two accepted, third blocked, then released in order
        i_ready = 1'b0;
        base = n_out;
        send(32'h0070_0193, 32'h200);
        send(32'h0020_8233, 32'h204);
        i_valid = 1'b1; i_instr = 32'h4020_82B3; i_pc = 32'h208;
        chk("stall_ready_low", o_ready, 1'b0);
        chk("stall_head_pc", o_pc, 32'h200);
        i_ready = 1'b1;
        send(32'h4020_82B3, 32'h208);
        wait_drain("stall_drain", 20);
        @(posedge i_clk); #1;
        chk("stall_emitted", n_out - base, 3);

        // Flush with the skid full
        i_ready = 1'b0;
        send(32'h0010_0313, 32'h300);
        send(32'h0020_0393, 32'h304);
        chk("flush_pre_ready", o_ready, 1'b0);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        chk("flush_valid", o_valid, 1'b0);
        chk("flush_ready", o_ready, 1'b1);
        // Instruction offered in a flush cycle must be dropped
        i_ready = 1'b1;
        i_flush = 1'b1; i_valid = 1'b1; i_instr = 32'h0050_0093; i_pc = 32'h308;
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_drop_valid", o_valid, 1'b0);

        // Asynchronous reset in the middle of a stall
        i_ready = 1'b0;
        send(32'h4030_D113, 32'h400);
        send(32'h0050_0093, 32'h404);
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_async_valid", o_valid, 1'b0);
        chk("rst_async_ready", o_ready, 1'b1);
        chk("rst_async_pc", o_pc, 32'h0);
        chk("rst_async_alu_op", o_alu_op, 4'h0);
        sb.delete();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("rst_release_valid", o_valid, 1'b0);

        // Randomized traffic with random backpressure and occasional flushes
        rand_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            int r = $urandom_range(0, 19);
            if (r == 0) begin
                i_flush = 1'b1;
                i_valid = ($urandom_range(0, 1) != 0);
                i_instr = gen_instr();
                i_pc    = $urandom & 32'hFFFF_FFFC;
                @(posedge i_clk); #1;
                i_flush = 1'b0;
                i_valid = 1'b0;
            end else if (r < 4) begin
                @(posedge i_clk); #1;
            end else begin
                send(gen_instr(), $urandom & 32'hFFFF_FFFC);
            end
        end
        rand_ready = 1'b0;
        @(posedge i_clk); #2;
        i_ready = 1'b1;
        wait_drain("random_drain", 20);
        @(posedge i_clk); #1;
        chk("final_idle_valid", o_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
